// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and constants for the vending machine controller
// Purpose: state encoding, coin codes, product codes and credit/price widths
//          used by payment_controller, coin_accumulator and product_selector.
// Ports:   none (package).
package vend_pkg;

  localparam int CREDIT_W = 6;
  localparam int PRICE_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_LATCH,
    ST_COLLECT,
    ST_DISPENSE,
    ST_SETTLE,
    ST_REFUND
  } state_t;

  typedef enum logic [1:0] {
    COIN_0   = 2'b00,
    COIN_1   = 2'b01,
    COIN_2   = 2'b10,
    COIN_BAD = 2'b11
  } coin_t;

  typedef enum logic [1:0] {
    PROD_0 = 2'b00,
    PROD_1 = 2'b01,
    PROD_2 = 2'b10
  } product_t;

  // Credit value of a coin code; the invalid code is worth nothing.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code,
                                                     input int v0,
                                                     input int v1,
                                                     input int v2);
    logic [CREDIT_W-1:0] v;
    case (code)
      COIN_0:  v = CREDIT_W'(v0);
      COIN_1:  v = CREDIT_W'(v1);
      COIN_2:  v = CREDIT_W'(v2);
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_accumulator.sv
// rtl/coin_accumulator.sv - coin valuation, credit register and coin rejection
// Purpose: adds accepted coins to the credit register and flags discarded coins.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   coin_valid      a coin is presented this cycle
//   coin_type       coin code, qualified by coin_valid
//   accept_en       coins may be accepted this cycle (controller in COLLECT)
//   clear           drop the accumulated credit at the next edge
//   credit          registered accumulated credit
//   credit_next     value credit will take at the next edge
//   coin_accepted   the presented coin is being added this cycle
//   coin_reject     one-cycle pulse: the previous cycle's coin was discarded
module coin_accumulator
  import vend_pkg::*;
#(
  parameter int COIN0_VALUE = 5,
  parameter int COIN1_VALUE = 10,
  parameter int COIN2_VALUE = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                accept_en,
  input  logic                clear,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] credit_next,
  output logic                coin_accepted,
  output logic                coin_reject
);

  assign coin_accepted = coin_valid && accept_en && (coin_type != COIN_BAD);

  always_comb begin
    credit_next = credit;
    if (clear) begin
      credit_next = '0;
    end else if (coin_accepted) begin
      credit_next = credit + coin_value(coin_type, COIN0_VALUE, COIN1_VALUE, COIN2_VALUE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit      <= '0;
      coin_reject <= 1'b0;
    end else begin
      credit      <= credit_next;
      coin_reject <= coin_valid && !coin_accepted;
    end
  end

endmodule

// File: rtl/payment_controller.sv
// rtl/payment_controller.sv - vending transaction controller (price fetch, credit, dispense, change)
// Purpose: runs one purchase: requests the price from product_selector, collects
//          coins, drives the dispense handshake and returns change or a refund.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   sel_req, cancel           one-cycle customer pulses
//   coin_valid, coin_type     coin presentation
//   product_price             price from the selector (0 = invalid product)
//   product_dispense_done     dispense acknowledge from the selector
//   signal_product_selector   request/hold of the selector price
//   product_dispense_en       dispense request
//   credit                    accumulated credit
//   change_out, change_valid  change/refund amount and its one-cycle strobe
//   coin_reject, sel_error    one-cycle error pulses
//   busy                      high whenever a transaction is in progress
module payment_controller
  import vend_pkg::*;
#(
  parameter int COIN0_VALUE    = 5,
  parameter int COIN1_VALUE    = 10,
  parameter int COIN2_VALUE    = 20,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel_req,
  input  logic                cancel,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic [PRICE_W-1:0]  product_price,
  input  logic                product_dispense_done,
  output logic                signal_product_selector,
  output logic                product_dispense_en,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] change_out,
  output logic                change_valid,
  output logic                coin_reject,
  output logic                sel_error,
  output logic                busy
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t               state;
  state_t               next_state;
  logic [PRICE_W-1:0]   price_q;
  logic [TIMER_W-1:0]   timer;
  logic [CREDIT_W-1:0]  credit_next;
  logic                 coin_accepted;
  logic                 timed_out;

  logic                 sps_d;
  logic                 en_d;
  logic [CREDIT_W-1:0]  change_d;
  logic                 change_valid_d;
  logic                 sel_error_d;
  logic                 busy_d;

  coin_accumulator #(
    .COIN0_VALUE(COIN0_VALUE),
    .COIN1_VALUE(COIN1_VALUE),
    .COIN2_VALUE(COIN2_VALUE)
  ) u_coin_accumulator (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .accept_en    (state == ST_COLLECT),
    .clear        ((state == ST_SETTLE) || (state == ST_REFUND)),
    .credit       (credit),
    .credit_next  (credit_next),
    .coin_accepted(coin_accepted),
    .coin_reject  (coin_reject)
  );

  assign timed_out = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

  // State register plus registered outputs, price latch and idle timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= ST_IDLE;
      price_q                 <= '0;
      timer                   <= '0;
      signal_product_selector <= 1'b0;
      product_dispense_en     <= 1'b0;
      change_out              <= '0;
      change_valid            <= 1'b0;
      sel_error               <= 1'b0;
      busy                    <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_LATCH) begin
        price_q <= product_price;
      end
      // Counts idle cycles in COLLECT; any accepted coin restarts it.
      if ((state == ST_COLLECT) && !coin_accepted) begin
        timer <= timer + 1'b1;
      end else begin
        timer <= '0;
      end
      signal_product_selector <= sps_d;
      product_dispense_en     <= en_d;
      change_out              <= change_d;
      change_valid            <= change_valid_d;
      sel_error               <= sel_error_d;
      busy                    <= busy_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (sel_req) next_state = ST_REQ;
      ST_REQ:      next_state = ST_LATCH;
      ST_LATCH:    next_state = (product_price == '0) ? ST_IDLE : ST_COLLECT;
      ST_COLLECT: begin
        // Cancel/timeout outrank the credit check.
        if (cancel || timed_out) begin
          next_state = ST_REFUND;
        end else if (credit >= CREDIT_W'(price_q)) begin
          next_state = ST_DISPENSE;
        end
      end
      ST_DISPENSE: if (product_dispense_done) next_state = ST_SETTLE;
      ST_SETTLE:   next_state = ST_IDLE;
      ST_REFUND:   next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next_state so the registered copies line up
  // with the state they belong to.
  always_comb begin
    sps_d          = (next_state != ST_IDLE);
    busy_d         = (next_state != ST_IDLE);
    en_d           = (next_state == ST_DISPENSE);
    sel_error_d    = (state == ST_LATCH) && (product_price == '0);
    change_valid_d = 1'b0;
    change_d       = '0;
    if (next_state == ST_SETTLE) begin
      change_valid_d = 1'b1;
      change_d       = credit - CREDIT_W'(price_q);
    end else if ((next_state == ST_REFUND) && (credit_next != '0)) begin
      // credit_next includes a coin arriving together with cancel.
      change_valid_d = 1'b1;
      change_d       = credit_next;
    end
  end

endmodule

// File: tb/tb_payment_controller.sv
// tb/tb_payment_controller.sv - self-checking bench for payment_controller
module tb_payment_controller;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_req;
  logic       cancel;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic [4:0] product_price;
  logic       product_dispense_done;
  logic       signal_product_selector;
  logic       product_dispense_en;
  logic [5:0] credit;
  logic [5:0] change_out;
  logic       change_valid;
  logic       coin_reject;
  logic       sel_error;
  logic       busy;

  payment_controller #(
    .COIN0_VALUE(5),
    .COIN1_VALUE(10),
    .COIN2_VALUE(20),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .sel_req                (sel_req),
    .cancel                 (cancel),
    .coin_valid             (coin_valid),
    .coin_type              (coin_type),
    .product_price          (product_price),
    .product_dispense_done  (product_dispense_done),
    .signal_product_selector(signal_product_selector),
    .product_dispense_en    (product_dispense_en),
    .credit                 (credit),
    .change_out             (change_out),
    .change_valid           (change_valid),
    .coin_reject            (coin_reject),
    .sel_error              (sel_error),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_change[$];
  int   exp_sel_err = 0;
  int   en_rises = 0;
  logic en_prev = 1'b0;
  bit   in_collect = 1'b0;
  int   m_credit = 0;
  int   cur_price = 0;
  bit   exp_reject = 1'b0;

  function automatic int coin_val(input logic [1:0] c);
    case (c)
      2'b00:   return 5;
      2'b01:   return 10;
      2'b10:   return 20;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a coin counts only while the purchase is collecting and the code is valid.
  always @(posedge clk) begin
    if (rst) begin
      exp_reject = 1'b0;
    end else begin
      exp_reject = coin_valid && !(in_collect && coin_type != 2'b11);
      if (coin_valid && in_collect && coin_type != 2'b11) m_credit += coin_val(coin_type);
    end
  end

  // Per-cycle comparison against the model and the expected event queues.
  always @(negedge clk) begin
    check("coin_reject", coin_reject, exp_reject);
    if (change_valid) begin
      if (exp_change.size() == 0) check("change_valid_unexpected", change_valid, 0);
      else check("change_out", change_out, exp_change.pop_front());
    end
    if (sel_error) begin
      check("sel_error_unexpected", (exp_sel_err > 0) ? 1 : 0, 1);
      if (exp_sel_err > 0) exp_sel_err--;
    end
    if (in_collect) check("credit_vs_model", credit, m_credit);
    if (product_dispense_en) check("en_implies_selector", signal_product_selector, 1);
    if (product_dispense_en && !en_prev) en_rises++;
    en_prev = product_dispense_en;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // sel_req sampled at edge N; returns just after edge N+2 (COLLECT for a valid price).
  task automatic start(input int price);
    product_price = 5'(price);
    cur_price = price;
    sel_req = 1'b1;
    tick();
    sel_req = 1'b0;
    tick();
    tick();
    if (price != 0) begin
      m_credit = 0;
      in_collect = 1'b1;
      check("collect_selector", signal_product_selector, 1);
      check("collect_busy", busy, 1);
    end
  endtask

  task automatic coin(input logic [1:0] c, input logic with_cancel);
    coin_valid = 1'b1;
    coin_type = c;
    cancel = with_cancel;
    tick();
    coin_valid = 1'b0;
    cancel = 1'b0;
    if (in_collect && (with_cancel || m_credit >= cur_price)) in_collect = 1'b0;
  endtask

  task automatic finish_dispense();
    int k;
    for (k = 0; k < 6 && !product_dispense_en; k++) tick();
    check("dispense_en_seen", product_dispense_en, 1);
    product_dispense_done = 1'b1;
    tick();
    product_dispense_done = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 20 && busy; k++) tick();
    check("idle_busy", busy, 0);
    check("idle_credit", credit, 0);
    check("idle_selector", signal_product_selector, 0);
    check("idle_dispense_en", product_dispense_en, 0);
    m_credit = 0;
    in_collect = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int k;
    rst = 1'b1;
    sel_req = 1'b0;
    cancel = 1'b0;
    coin_valid = 1'b0;
    coin_type = 2'b00;
    product_price = 5'd0;
    product_dispense_done = 1'b0;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_credit", credit, 0);
    check("reset_change_valid", change_valid, 0);
    check("reset_selector", signal_product_selector, 0);
    rst = 1'b0;
    tick();

    // Exact payment: price 15, coins 10 + 5, change 0.
    e0 = en_rises;
    start(15);
    check("exact_credit0", credit, 0);
    coin(2'b01, 1'b0);
    check("exact_credit10", credit, 10);
    exp_change.push_back(0);
    coin(2'b00, 1'b0);
    check("exact_model15", m_credit, 15);
    finish_dispense();
    wait_idle();
    check("exact_dispense_count", en_rises - e0, 1);

    // Overpay: price 25, coins 20 + 20, change 15.
    e0 = en_rises;
    start(25);
    coin(2'b10, 1'b0);
    exp_change.push_back(15);
    coin(2'b10, 1'b0);
    check("overpay_credit40", credit, 40);
    finish_dispense();
    wait_idle();
    check("overpay_dispense_count", en_rises - e0, 1);

    // Cancel with a coin in the same cycle: refund 15, no dispense.
    e0 = en_rises;
    start(20);
    coin(2'b01, 1'b0);
    exp_change.push_back(15);
    coin(2'b00, 1'b1);
    check("cancel_model15", m_credit, 15);
    wait_idle();
    check("cancel_dispense_count", en_rises - e0, 0);

    // Timeout with one coin: refund of 5 within T cycles of the coin.
    e0 = en_rises;
    start(15);
    coin(2'b00, 1'b0);
    exp_change.push_back(5);
    for (k = 1; k <= 12; k++) begin
      tick();
      if (change_valid) break;
    end
    check("timeout_within_T", (k >= 1 && k <= T) ? 1 : 0, 1);
    in_collect = 1'b0;
    wait_idle();
    check("timeout_dispense_count", en_rises - e0, 0);

    // Timeout with no coin: back to idle, no change pulse.
    start(15);
    for (k = 0; k < 15 && busy; k++) tick();
    in_collect = 1'b0;
    wait_idle();

    // Selector returns price 0 (product code 11): sel_error pulse, back to IDLE.
    exp_sel_err = 1;
    start(0);
    check("sel_error_pulse", sel_error, 1);
    check("sel_error_busy", busy, 0);
    tick();
    check("sel_error_one_cycle", sel_error, 0);
    check("sel_error_consumed", exp_sel_err, 0);

    // Invalid coin code in COLLECT is rejected and leaves credit alone.
    start(15);
    coin(2'b11, 1'b0);
    check("badcoin_reject", coin_reject, 1);
    check("badcoin_credit", credit, 0);
    exp_change.push_back(5);
    coin(2'b10, 1'b0);
    finish_dispense();
    wait_idle();

    // Coin while IDLE is rejected.
    coin(2'b01, 1'b0);
    check("idle_coin_reject", coin_reject, 1);
    check("idle_coin_credit", credit, 0);
    tick();

    // Reset during DISPENSE: everything clears, no change pulse.
    start(10);
    coin(2'b01, 1'b0);
    for (k = 0; k < 6 && !product_dispense_en; k++) tick();
    check("rst_dispense_reached", product_dispense_en, 1);
    rst = 1'b1;
    tick();
    check("rst_dispense_en", product_dispense_en, 0);
    check("rst_credit", credit, 0);
    check("rst_busy", busy, 0);
    check("rst_change_valid", change_valid, 0);
    check("rst_selector", signal_product_selector, 0);
    rst = 1'b0;
    m_credit = 0;
    tick();

    // A fresh purchase completes normally afterwards.
    e0 = en_rises;
    start(10);
    exp_change.push_back(0);
    coin(2'b01, 1'b0);
    finish_dispense();
    wait_idle();
    check("after_rst_dispense_count", en_rises - e0, 1);

    tick();
    check("pending_changes", exp_change.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
